// File: rtl/jtag_vector_pkg.sv
// Shared types for the JTAG vector driver: command word, FSM states, LFSR constants.
// Chain indices are carried at a fixed maximum width; drivers narrow them to their own CHAIN_W.
package jtag_vector_pkg;

  localparam int JTAG_CHAIN_MAX_W = 8;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting form of taps 16,14,13,11: feedback from bits 0,2,3,5 enters at bit 15.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef struct packed {
    logic                        tms;
    logic                        tdi;
    logic                        trstn;
    logic                        capture;
    logic                        exit;
    logic [JTAG_CHAIN_MAX_W-1:0] chain;
  } jtag_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_RSP
  } jtag_drv_state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

endpackage

// File: rtl/jtag_cmd_fifo.sv
// Synchronous command FIFO, DEPTH (power of two) entries; head is visible combinationally.
// Push and pop may coincide; the caller must not push when full or pop when empty.
module jtag_cmd_fifo
  import jtag_vector_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  jtag_cmd_t push_data,
  input  logic      pop,
  output jtag_cmd_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  jtag_cmd_t   mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // Extra pointer bit tells full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/jtag_vector_driver.sv
// Plays buffered TMS/TDI/TRSTn bits onto one of NUM_CHAINS TAPs; each bit costs 2*(TICK_DELAY+1)+1 cycles.
// cmd_ready = FIFO not full; a captured bit stalls TCK until rsp_ready. JTAG_VECTOR_RANDOM_TDO_EN: LFSR for undriven TDO.
module jtag_vector_driver
  import jtag_vector_pkg::*;
#(
  parameter int TICK_DELAY = 50,
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_CHAINS = 2,
  parameter int CHAIN_W    = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  init_done,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_tms,
  input  logic                  cmd_tdi,
  input  logic                  cmd_trstn,
  input  logic                  cmd_capture,
  input  logic                  cmd_exit,
  input  logic [CHAIN_W-1:0]    cmd_chain,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_tdo,
  output logic [CHAIN_W-1:0]    rsp_chain,
  output logic [NUM_CHAINS-1:0] jtag_TCK,
  output logic [NUM_CHAINS-1:0] jtag_TMS,
  output logic [NUM_CHAINS-1:0] jtag_TDI,
  output logic [NUM_CHAINS-1:0] jtag_TRSTn,
  input  logic [NUM_CHAINS-1:0] jtag_TDO_data,
  input  logic [NUM_CHAINS-1:0] jtag_TDO_driven,
  output logic [31:0]           exit
);

  localparam int               CNT_W  = (TICK_DELAY > 0) ? $clog2(TICK_DELAY + 1) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICK_DELAY);

  jtag_drv_state_e state, next_state;

  jtag_cmd_t          push_cmd;
  jtag_cmd_t          head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               chain_ok;
  logic               init_seen;
  logic               trst_release;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_zero;
  logic               cur_capture;
  logic [CHAIN_W-1:0] cur_chain;
  logic               tdo_q;
  logic               sub_bit;
  logic               sample_bit;
  logic               load;
  logic               do_exit;
  logic               tck_rise;
  logic               tck_fall;
  logic               rsp_done;

  assign push_cmd = '{
    tms:     cmd_tms,
    tdi:     cmd_tdi,
    trstn:   cmd_trstn,
    capture: cmd_capture,
    exit:    cmd_exit,
    chain:   JTAG_CHAIN_MAX_W'(cmd_chain)
  };

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && !fifo_full;
  assign chain_ok  = (head.chain < JTAG_CHAIN_MAX_W'(NUM_CHAINS));
  assign cnt_zero  = (cnt == '0);
  assign rsp_tdo   = tdo_q;
  assign rsp_chain = cur_chain;

  jtag_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_cmd),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef JTAG_VECTOR_RANDOM_TDO_EN
  logic [15:0] lfsr;

  always_ff @(posedge clock) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= lfsr_next(lfsr);
  end

  assign sub_bit = lfsr[0];
`else
  assign sub_bit = 1'b0;
`endif

  always_comb begin
    sample_bit = 1'b0;
    for (int c = 0; c < NUM_CHAINS; c++) begin
      if (cur_chain == CHAIN_W'(c)) sample_bit = jtag_TDO_driven[c] ? jtag_TDO_data[c] : sub_bit;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    load       = 1'b0;
    do_exit    = 1'b0;
    tck_rise   = 1'b0;
    tck_fall   = 1'b0;
    rsp_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && enable && init_seen) begin
          pop = 1'b1;
          // Commands aimed at a chain that does not exist are dropped silently.
          if (head.exit) begin
            do_exit = 1'b1;
          end else if (chain_ok) begin
            load       = 1'b1;
            next_state = ST_LOW;
          end
        end
      end
      ST_LOW: begin
        if (cnt_zero) begin
          tck_rise   = 1'b1;
          next_state = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (cnt_zero) begin
          tck_fall   = 1'b1;
          next_state = cur_capture ? ST_RSP : ST_IDLE;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          rsp_done   = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      jtag_TCK     <= '0;
      jtag_TMS     <= '1;
      jtag_TDI     <= '0;
      jtag_TRSTn   <= '0;
      rsp_valid    <= 1'b0;
      exit         <= '0;
      init_seen    <= 1'b0;
      trst_release <= 1'b1;
      cnt          <= '0;
      cur_capture  <= 1'b0;
      cur_chain    <= '0;
      tdo_q        <= 1'b0;
    end else begin
      if (init_done) init_seen <= 1'b1;
      if (trst_release) begin
        trst_release <= 1'b0;
        jtag_TRSTn   <= '1;
      end
      if (do_exit) exit <= 32'd1;

      if (load) begin
        cur_capture <= head.capture;
        cur_chain   <= head.chain[CHAIN_W-1:0];
        cnt         <= RELOAD;
        for (int c = 0; c < NUM_CHAINS; c++) begin
          if (head.chain == JTAG_CHAIN_MAX_W'(c)) begin
            jtag_TMS[c]   <= head.tms;
            jtag_TDI[c]   <= head.tdi;
            jtag_TRSTn[c] <= head.trstn;
            jtag_TCK[c]   <= 1'b0;
          end
        end
      end else if (state == ST_LOW || state == ST_HIGH) begin
        cnt <= cnt_zero ? RELOAD : cnt - 1'b1;
      end

      if (tck_rise) begin
        tdo_q <= sample_bit;
        for (int c = 0; c < NUM_CHAINS; c++) begin
          if (cur_chain == CHAIN_W'(c)) jtag_TCK[c] <= 1'b1;
        end
      end

      if (tck_fall) begin
        if (cur_capture) rsp_valid <= 1'b1;
        for (int c = 0; c < NUM_CHAINS; c++) begin
          if (cur_chain == CHAIN_W'(c)) jtag_TCK[c] <= 1'b0;
        end
      end

      if (rsp_done) rsp_valid <= 1'b0;
    end
  end

endmodule
